pkt_framer: RTL and testbench

Upstream stage of the sequence parser. Accepts a per-packet command (stream id, message length) plus a raw 32-bit payload word stream. Emits framed packets on the parser's 32-bit val/ready/last input bus.
- Word 0: little-endian msgLen/streamId header.
- Word 1: little-endian per-stream sequence number.
- Words 2..N: payload.
Sequence numbers are tracked and auto-incremented per stream.

---
 rtl/pkt_pkg.sv | 16 +
 rtl/pkt_framer_if.sv | 37 +++
 rtl/pkt_seq_table.sv | 28 ++
 rtl/pkt_framer.sv | 117 +++++++++++
 tb/tb_pkt_framer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_pkg.sv
// pkt_pkg: shared framer/parser types, sizes and little-endian byte-swap helpers.
//   state_t          framer FSM states
//   HDR_BYTES        header bytes counted in msgLen (word0 + word1)
//   WORD_BYTES       bytes per bus word
//   to_le16/to_le32  byte swap into on-the-wire little-endian order
package pkt_pkg;
    typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAYLOAD} state_t;
    localparam int HDR_BYTES = 8;
    localparam int WORD_BYTES = 4;
    function automatic logic [15:0] to_le16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction
    function automatic logic [31:0] to_le32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction
endpackage

// File: rtl/pkt_framer_if.sv
// pkt_framer_if: command, payload and framed-output buses of the packet framer.
//   cmd_*      per-packet command (stream id, msgLen) and drop pulse cmd_err
//   pay_*      raw payload word stream
//   dataOut*   framed val/ready/last output to the parser
// Optional macro SEQ_GAP_INJECT_EN adds cmd_skip (sampled with the command).
// Modports: slave = framer side, master = environment side.
interface pkt_framer_if;
    logic        cmd_val;
    logic        cmd_ready;
    logic [15:0] cmd_stream;
    logic [15:0] cmd_len;
    logic        cmd_err;
`ifdef SEQ_GAP_INJECT_EN
    logic        cmd_skip;
`endif
    logic [31:0] pay_data;
    logic        pay_val;
    logic        pay_ready;
    logic [31:0] dataOut;
    logic        dataOut_val;
    logic        dataOut_ready;
    logic        dataOut_last;
    modport slave (
        input  cmd_val, cmd_stream, cmd_len, pay_data, pay_val, dataOut_ready,
`ifdef SEQ_GAP_INJECT_EN
        input  cmd_skip,
`endif
        output cmd_ready, cmd_err, pay_ready, dataOut, dataOut_val, dataOut_last
    );
    modport master (
        output cmd_val, cmd_stream, cmd_len, pay_data, pay_val, dataOut_ready,
`ifdef SEQ_GAP_INJECT_EN
        output cmd_skip,
`endif
        input  cmd_ready, cmd_err, pay_ready, dataOut, dataOut_val, dataOut_last
    );
endinterface

// File: rtl/pkt_seq_table.sv
// pkt_seq_table: NUM_STREAMS x 32-bit sequence register file, reset to SEQ_INIT.
//   clk, reset          clock, synchronous active-high reset
//   rd_idx_i/rd_data_o  combinational read port
//   we_i/wr_idx_i/wr_data_i  synchronous write port
module pkt_seq_table #(
    parameter int          NUM_STREAMS = 16,
    parameter logic [31:0] SEQ_INIT    = 32'd1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(NUM_STREAMS)-1:0] rd_idx_i,
    output logic [31:0]                    rd_data_o,
    input  logic                           we_i,
    input  logic [$clog2(NUM_STREAMS)-1:0] wr_idx_i,
    input  logic [31:0]                    wr_data_i
);
    logic [31:0] tbl_q [NUM_STREAMS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STREAMS; i++) tbl_q[i] <= SEQ_INIT;
        end else if (we_i) begin
            tbl_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = tbl_q[rd_idx_i];
endmodule

// File: rtl/pkt_framer.sv
// pkt_framer: frames command + payload words into header/seq/payload packets.
//   clk, reset  clock, synchronous active-high reset
//   bus         pkt_framer_if.slave: cmd_* command, pay_* payload, dataOut* framed output
// Word0 = LE {msgLen, streamId}, word1 = LE per-stream seq, then ceil(len/4)-2 payload words.
// Optional macro SEQ_GAP_INJECT_EN: cmd_skip=1 uses seq+1 and stores seq+2.
module pkt_framer
    import pkt_pkg::*;
#(
    parameter int          NUM_STREAMS = 16,
    parameter logic [31:0] SEQ_INIT    = 32'd1
) (
    input logic         clk,
    input logic         reset,
    pkt_framer_if.slave bus
);
    localparam int IW = $clog2(NUM_STREAMS);

    state_t      state_q;
    logic [15:0] stream_q;
    logic [15:0] len_q;
    logic [31:0] seq_q;
    logic [13:0] cnt_q;
    logic [31:0] data_q;
    logic        val_q;
    logic        last_q;
    logic        err_q;

    logic          adv;
    logic          accept;
    logic          len_ok;
    logic          tbl_we;
    logic [IW-1:0] idx;
    logic [31:0]   tbl_rd;
    logic [31:0]   seq_d;
    logic [14:0]   words;
    logic [13:0]   cnt_d;

    // Output register may load when empty or being drained this cycle.
    assign adv           = !val_q || bus.dataOut_ready;
    assign bus.cmd_ready = !reset && state_q == IDLE && adv;
    assign bus.pay_ready = !reset && state_q == PAYLOAD && adv;
    assign accept        = bus.cmd_val && bus.cmd_ready;
    assign len_ok        = bus.cmd_len >= 16'(HDR_BYTES);
    assign tbl_we        = accept && len_ok;
    assign idx           = bus.cmd_stream[IW-1:0];
    assign words         = 15'((32'(bus.cmd_len) + 32'(WORD_BYTES - 1)) / WORD_BYTES);
    assign cnt_d         = 14'(words - 15'd2);
`ifdef SEQ_GAP_INJECT_EN
    assign seq_d = tbl_rd + {31'd0, bus.cmd_skip};
`else
    assign seq_d = tbl_rd;
`endif

    pkt_seq_table #(.NUM_STREAMS(NUM_STREAMS), .SEQ_INIT(SEQ_INIT)) u_seq (
        .clk      (clk),
        .reset    (reset),
        .rd_idx_i (idx),
        .rd_data_o(tbl_rd),
        .we_i     (tbl_we),
        .wr_idx_i (idx),
        .wr_data_i(seq_d + 32'd1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            stream_q <= '0;
            len_q    <= '0;
            seq_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            val_q    <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= accept && !len_ok;
            // Drained word leaves the register unless a new one loads below.
            if (adv) begin
                val_q  <= 1'b0;
                last_q <= 1'b0;
            end
            case (state_q)
                IDLE: if (tbl_we) begin
                    stream_q <= bus.cmd_stream;
                    len_q    <= bus.cmd_len;
                    seq_q    <= seq_d;
                    cnt_q    <= cnt_d;
                    state_q  <= HDR0;
                end
                HDR0: if (adv) begin
                    data_q  <= {to_le16(len_q), to_le16(stream_q)};
                    val_q   <= 1'b1;
                    state_q <= HDR1;
                end
                HDR1: if (adv) begin
                    data_q  <= to_le32(seq_q);
                    val_q   <= 1'b1;
                    last_q  <= cnt_q == '0;
                    state_q <= cnt_q == '0 ? IDLE : PAYLOAD;
                end
                PAYLOAD: if (bus.pay_val && bus.pay_ready) begin
                    data_q  <= bus.pay_data;
                    val_q   <= 1'b1;
                    last_q  <= cnt_q == 14'd1;
                    cnt_q   <= cnt_q - 14'd1;
                    state_q <= cnt_q == 14'd1 ? IDLE : PAYLOAD;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dataOut      = data_q;
    assign bus.dataOut_val  = val_q;
    assign bus.dataOut_last = last_q;
    assign bus.cmd_err      = err_q;
endmodule

// File: tb/tb_pkt_framer.sv
// tb_pkt_framer: scoreboard bench for pkt_framer (directed packets, reset, drop, backpressure).
module tb_pkt_framer;
    logic clk = 1'b0;
    logic reset = 1'b1;

    pkt_framer_if bus();
    pkt_framer #(.NUM_STREAMS(16), .SEQ_INIT(32'd1)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [32:0] exp_q [$];
    logic [31:0] pay_q [$];
    logic [32:0] w;
    logic [32:0] held_w;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int gaps = 0;
    int prev_hs = -1;
    int err_pulses = 0;
    bit toggle = 0;
    bit pr_seen = 0;
    bit held = 0;
`ifdef SEQ_GAP_INJECT_EN
    bit skip_v = 0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Payload source and downstream ready driver.
    initial begin
        bus.pay_val = 1'b0;
        bus.pay_data = '0;
        bus.dataOut_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.dataOut_ready = toggle ? !bus.dataOut_ready : 1'b1;
            bus.pay_val = pay_q.size() != 0;
            bus.pay_data = pay_q.size() != 0 ? pay_q[0] : 32'h0;
            #1;
            if (bus.pay_val && bus.pay_ready) void'(pay_q.pop_front());
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (reset) begin
                held = 0;
                prev_hs = -1;
                continue;
            end
            if (bus.cmd_err) err_pulses++;
            if (bus.pay_ready) pr_seen = 1;
            if (held)
                check("hold", 64'({bus.dataOut_val, bus.dataOut_last, bus.dataOut}), 64'({1'b1, held_w}));
            held = bus.dataOut_val && !bus.dataOut_ready;
            held_w = {bus.dataOut_last, bus.dataOut};
            if (bus.dataOut_val && bus.dataOut_ready) begin
                hs_cnt++;
                if (prev_hs >= 0 && cyc != prev_hs + 1) gaps++;
                prev_hs = bus.dataOut_last ? -1 : cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h with nothing expected", {bus.dataOut_last, bus.dataOut});
                end else begin
                    w = exp_q.pop_front();
                    check("word", 64'({bus.dataOut_last, bus.dataOut}), 64'(w));
                end
            end
        end
    end

    task automatic expect_pkt(input logic [31:0] w0, input logic [31:0] w1, input int p, input logic [7:0] tag);
        logic [31:0] d;
        exp_q.push_back({1'b0, w0});
        exp_q.push_back({p == 0, w1});
        for (int i = 0; i < p; i++) begin
            d = {tag, 24'(i)};
            exp_q.push_back({i == p - 1, d});
            pay_q.push_back(d);
        end
    endtask

    task automatic send(input logic [15:0] s, input logic [15:0] l);
        int n = 0;
        @(negedge clk);
        bus.cmd_val = 1'b1;
        bus.cmd_stream = s;
        bus.cmd_len = l;
`ifdef SEQ_GAP_INJECT_EN
        bus.cmd_skip = skip_v;
`endif
        #1;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout: got cmd_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        bus.cmd_val = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || pay_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #3;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset();
        check("rst_val", 64'(bus.dataOut_val), 64'd0);
        check("rst_last", 64'(bus.dataOut_last), 64'd0);
        check("rst_data", 64'(bus.dataOut), 64'd0);
        check("rst_err", 64'(bus.cmd_err), 64'd0);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("rst_pay_ready", 64'(bus.pay_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, e0, h0, n;
        bus.cmd_val = 1'b0;
        bus.cmd_stream = '0;
        bus.cmd_len = '0;
`ifdef SEQ_GAP_INJECT_EN
        bus.cmd_skip = 1'b0;
`endif
        @(posedge clk);
        #1;
        chk_reset();
        @(negedge clk);
        reset = 1'b0;

        g0 = gaps;
        expect_pkt(32'h14000C00, 32'h01000000, 3, 8'hA1);
        send(16'd12, 16'd20);
        wait_drain("drain_len20");
        check("no_bubbles", 64'(gaps - g0), 64'd0);

        expect_pkt(32'h15000C00, 32'h02000000, 4, 8'hB1);
        send(16'd12, 16'd21);
        expect_pkt(32'h16000C00, 32'h03000000, 4, 8'hB2);
        send(16'd12, 16'd22);
        wait_drain("drain_len21_22");

        pr_seen = 0;
        expect_pkt(32'h08000E00, 32'h01000000, 0, 8'h00);
        send(16'd14, 16'd8);
        wait_drain("drain_len8");
        check("pay_ready_idle", 64'(pr_seen), 64'd0);

        e0 = err_pulses;
        send(16'd15, 16'd5);
        repeat (4) @(negedge clk);
        #3;
        check("err_pulse", 64'(err_pulses - e0), 64'd1);
        check("err_no_words", 64'(exp_q.size()), 64'd0);
        expect_pkt(32'h09000F00, 32'h01000000, 1, 8'hC1);
        send(16'd15, 16'd9);
        wait_drain("drain_len9");

        toggle = 1;
        expect_pkt(32'h2D000C00, 32'h04000000, 10, 8'hD1);
        send(16'd12, 16'd45);
        wait_drain("drain_len45");
        toggle = 0;

        h0 = hs_cnt;
        n = 0;
        expect_pkt(32'h14000C00, 32'h05000000, 3, 8'hE1);
        send(16'd12, 16'd20);
        while (hs_cnt < h0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midpkt_words", 64'(hs_cnt >= h0 + 3), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #3;
        exp_q.delete();
        pay_q.delete();
        @(posedge clk);
        #1;
        chk_reset();
        @(negedge clk);
        reset = 1'b0;

        expect_pkt(32'h08000C00, 32'h01000000, 0, 8'h00);
        send(16'd12, 16'd8);
        expect_pkt(32'h08000F00, 32'h01000000, 0, 8'h00);
        send(16'd15, 16'd8);
        wait_drain("drain_after_reset");

`ifdef SEQ_GAP_INJECT_EN
        expect_pkt(32'h08000C00, 32'h02000000, 0, 8'h00);
        send(16'd12, 16'd8);
        expect_pkt(32'h08000C00, 32'h03000000, 0, 8'h00);
        send(16'd12, 16'd8);
        skip_v = 1;
        expect_pkt(32'h14000C00, 32'h05000000, 3, 8'hF1);
        send(16'd12, 16'd20);
        skip_v = 0;
        expect_pkt(32'h08000C00, 32'h06000000, 0, 8'h00);
        send(16'd12, 16'd8);
        wait_drain("drain_skip");
`endif

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
